// File: rtl/right_shift_reg.sv
// Serial-in, parallel-out right-shift register.
// The serial bit enters at the MSB; the bit leaving the LSB is presented,
// registered, on out_bit one edge later.
module right_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  output logic [WIDTH-1:0] q,
  output logic             out_bit
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             out_bit_q, out_bit_d;

  // Next state: new bit into the MSB, everything else moves toward the LSB
  always_comb begin
    q_d       = {in_bit, q_q[WIDTH-1:1]};
    out_bit_d = q_q[0];
  end

  // State register with synchronous reset taking priority over the shift
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      out_bit_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      out_bit_q <= out_bit_d;
    end
  end

  assign q       = q_q;
  assign out_bit = out_bit_q;

endmodule

// File: tb/tb_right_shift_reg.sv
// Bench for right_shift_reg: a WIDTH=4 and a WIDTH=8 instance share stimulus.
// A history-based model predicts both every cycle; directed literals pin it.
module tb_right_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic [3:0] q4;
  logic       ob4;
  logic [7:0] q8;
  logic       ob8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  right_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .q(q4), .out_bit(ob4)
  );

  right_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .q(q8), .out_bit(ob8)
  );

  always #5 clk = ~clk;

  // Model: list of bits accepted since the last reset edge, newest last.
  bit hist[$];
  bit valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      valid = 1'b1;
    end else begin
      hist.push_back(in_bit);
    end
  end

  // Bit that entered `age` edges ago (age 0 = most recent), 0 if none since reset
  function automatic bit bit_aged(int unsigned age);
    int unsigned n;
    n = hist.size();
    if (n > age) return hist[n-1-age];
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_q(int unsigned w);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) r[i] = bit_aged(w - 1 - i);
    return r;
  endfunction

  function automatic logic exp_ob(int unsigned w);
    return bit_aged(w);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model once a reset edge has occurred
  always @(negedge clk) begin
    if (valid) begin
      chk("model_q4",  {4'b0, q4},  exp_q(4));
      chk("model_ob4", {7'b0, ob4}, {7'b0, exp_ob(4)});
      chk("model_q8",  q8,          exp_q(8));
      chk("model_ob8", {7'b0, ob8}, {7'b0, exp_ob(8)});
    end
  end

  // Apply inputs, take one rising edge, return at the following falling edge
  task automatic step(input logic r, input logic b);
    rst    = r;
    in_bit = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit4(input string name, input logic [3:0] eq, input logic eob);
    chk({name, "_q"},  {4'b0, q4},  {4'b0, eq});
    chk({name, "_ob"}, {7'b0, ob4}, {7'b0, eob});
  endtask

  initial begin
    rst    = 1'b1;
    in_bit = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lit4("reset", 4'b0000, 1'b0);

    // Shift in 1,1,0,1
    step(0, 1); lit4("sh1", 4'b1000, 1'b0);
    step(0, 1); lit4("sh2", 4'b1100, 1'b0);
    step(0, 0); lit4("sh3", 4'b0110, 1'b0);
    step(0, 1); lit4("sh4", 4'b1011, 1'b0);

    // Shift out with zeros
    step(0, 0); lit4("out1", 4'b0101, 1'b1);
    step(0, 0); lit4("out2", 4'b0010, 1'b1);
    step(0, 0); lit4("out3", 4'b0001, 1'b0);
    step(0, 0); lit4("out4", 4'b0000, 1'b1);

    // Mid-stream reset from 1011
    step(1, 0);
    step(0, 1); step(0, 1); step(0, 0); step(0, 1);
    lit4("pre_mid", 4'b1011, 1'b0);
    step(1, 1); lit4("mid_rst", 4'b0000, 1'b0);
    step(0, 1); lit4("mid_rel", 4'b1000, 1'b0);

    // Fill with ones
    step(1, 0);
    step(0, 1); lit4("fill1", 4'b1000, 1'b0);
    step(0, 1); lit4("fill2", 4'b1100, 1'b0);
    step(0, 1); lit4("fill3", 4'b1110, 1'b0);
    step(0, 1); lit4("fill4", 4'b1111, 1'b0);
    step(0, 1); lit4("fill5", 4'b1111, 1'b1);

    // WIDTH=8: a single 1 followed by zeros travels through
    step(1, 1);
    step(0, 1);
    chk("w8_msb", {7'b0, q8[7]}, 8'd1);
    chk("w8_e1",  q8, 8'b1000_0000);
    for (int i = 0; i < 7; i++) step(0, 0);
    chk("w8_lsb", {7'b0, q8[0]}, 8'd1);
    chk("w8_e8",  q8, 8'b0000_0001);
    chk("w8_ob8", {7'b0, ob8}, 8'd0);
    step(0, 0);
    chk("w8_e9_ob", {7'b0, ob8}, 8'd1);
    chk("w8_e9_q",  q8, 8'b0000_0000);

    // Pseudo-random tail, checked by the model only
    for (int i = 0; i < 40; i++) step((i % 17) == 16, 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
